i2c_passthru_bus_recovery: RTL and testbench
============================================

Name: i2c_passthru_bus_recovery

Overview:
- Sequencer that frees a hung I2C bus after the passthru has disconnected the two channels because of a stuck or violation condition.
- Drives SCL pulses (open-drain pull-low enables) on both channel A and channel B until both SDA lines read high, or until a pulse limit is reached.
- On success it issues a STOP condition on both channels, so the master-detect FSM sees both channels idle and returns to idle.
- Sits beside the master detector; its enables are OR-ed into the per-channel pad pull-downs.

Parameters:
- CLK_DIV, 250, i_clk cycles per SCL half-period (legal range 2..65535).
- PULSE_MAX, 9, maximum SCL pulses per recovery attempt (legal range 1..15).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_start  in  1  recovery request, sampled in IDLE only.
- i_disconnect  in  1  passthru disconnected; recovery runs only while this is 1.
- i_sda_a  in  1  synchronized SDA, channel A.
- i_sda_b  in  1  synchronized SDA, channel B.
- i_scl_a  in  1  synchronized SCL, channel A; used only with the optional feature.
- i_scl_b  in  1  synchronized SCL, channel B; used only with the optional feature.
- o_scl_a_oe  out  1  1 pulls SCL A low.
- o_sda_a_oe  out  1  1 pulls SDA A low.
- o_scl_b_oe  out  1  1 pulls SCL B low.
- o_sda_b_oe  out  1  1 pulls SDA B low.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse: bus freed and STOP issued.
- o_fail  out  1  one-cycle pulse: SDA still low after PULSE_MAX pulses.

Behaviour:
- All outputs are registered. Reset (i_rst=1 at a clock edge) forces IDLE, pulse count 0, timer 0, and every output 0 from the next cycle, including when reset arrives mid-sequence.
- SCL/SDA pull-downs are identical on A and B at all times.
- Phase timer loads CLK_DIV-1 on phase entry and counts down. The phase ends in the cycle the timer reads 0, so each phase lasts exactly CLK_DIV cycles.
- IDLE: all outputs 0. If i_start=1 and i_disconnect=1, go to LOW next cycle. Otherwise stay.
- LOW: scl_oe=1, sda_oe=0, busy=1. At phase end, increment the pulse count and go to HIGH.
- HIGH: scl_oe=0, sda_oe=0, busy=1. In the phase's last cycle, sample i_sda_a and i_sda_b:
  - both 1: go to STOP_A;
  - else, count < PULSE_MAX: go to LOW;
  - else: go to FAIL.
- STOP_A: scl_oe=1, sda_oe=1, for CLK_DIV cycles.
- STOP_B: scl_oe=0, sda_oe=1, for CLK_DIV cycles.
- STOP_C: both released, for CLK_DIV cycles (bus-free time). Then go to DONE.
- DONE: o_done=1, o_busy=0, for one cycle; then IDLE.
- FAIL: o_fail=1, o_busy=0, all oe 0, for one cycle; then IDLE. No STOP is issued on failure.
- At least one SCL pulse is always issued, even if both SDA lines are already high at start.
- i_start while busy is ignored. i_start with i_disconnect=0 is ignored.
- i_disconnect falling in any busy state: next cycle all oe=0, state IDLE, no o_done or o_fail. This abort takes precedence over a phase end in the same cycle.
- i_rst takes precedence over everything.
- Pulse count is 4 bits and is cleared on IDLE exit. Timer width is clog2(CLK_DIV).

Optional Feature:
- Macro: I2C_PASSTHRU_RECOVERY_STRETCH_EN.
- Defined: in HIGH, the timer holds (does not decrement) while i_scl_a=0 or i_scl_b=0, so slave clock stretching lengthens the high phase.
- Undefined: i_scl_a and i_scl_b are ignored and HIGH lasts exactly CLK_DIV cycles.

Decomposition:
- Shared package/header (i2c_passthru_pkg) holds:
  - the state encoding constants (IDLE, LOW, HIGH, STOP_A, STOP_B, STOP_C, DONE, FAIL; 3 bits);
  - the default CLK_DIV and PULSE_MAX values.
- One natural sub-module, i2c_passthru_phase_timer: reloadable down-counter with load, hold and zero-flag outputs, parameterized by CLK_DIV.

Test Plan (CLK_DIV=4, PULSE_MAX=9, i_start pulsed at cycle 0, i_disconnect=1 unless stated):
- Both SDA high throughout -> scl_oe=1 cycles 1-4, released 5-8; STOP_A 9-12 (scl_oe=sda_oe=1); STOP_B 13-16 (sda_oe=1 only); STOP_C 17-20; o_done=1 at cycle 21 only; o_busy=1 cycles 1-20.
- i_sda_b held low, released during the 3rd HIGH phase -> exactly 3 scl_oe low pulses, then the STOP sequence, then o_done; o_fail never asserts.
- i_sda_a stuck low -> 9 pulses; o_fail=1 for one cycle at cycle 73 (cycle after the 9th HIGH phase ends); sda_oe never asserts; o_done stays 0.
- i_disconnect dropped at cycle 6 (HIGH phase of pulse 1) -> cycle 7 all oe=0, o_busy=0; no o_done or o_fail.
- i_start repeated at cycle 3 -> ignored, timing identical to the first scenario.
- i_start with i_disconnect=0 -> no response; i_rst asserted at cycle 14 -> all outputs 0 at cycle 15, and a fresh i_start restarts from pulse 1.
- Stretch macro defined, i_scl_a held low 6 cycles in the first HIGH phase -> HIGH lasts 10 cycles.

Source files
------------

// File: rtl/i2c_passthru_bus_recovery_pkg.sv
// Shared types for the I2C passthru bus-recovery sequencer: state encoding,
// default timing parameters and the registered-output decode.
package i2c_passthru_pkg;

   localparam int CLK_DIV_DEFAULT   = 250;
   localparam int PULSE_MAX_DEFAULT = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOW    = 3'd1,
      ST_HIGH   = 3'd2,
      ST_STOP_A = 3'd3,
      ST_STOP_B = 3'd4,
      ST_STOP_C = 3'd5,
      ST_DONE   = 3'd6,
      ST_FAIL   = 3'd7
   } state_e;

   typedef struct packed {
      logic scl_oe;
      logic sda_oe;
      logic busy;
      logic done;
      logic fail;
   } out_t;

   // Output pattern for a state; pull-downs are shared by channel A and B.
   function automatic out_t decode_outputs(state_e st);
      out_t o;
      o = '0;
      case (st)
         ST_LOW:    begin o.scl_oe = 1'b1; o.busy = 1'b1; end
         ST_HIGH:   o.busy = 1'b1;
         ST_STOP_A: begin o.scl_oe = 1'b1; o.sda_oe = 1'b1; o.busy = 1'b1; end
         ST_STOP_B: begin o.sda_oe = 1'b1; o.busy = 1'b1; end
         ST_STOP_C: o.busy = 1'b1;
         ST_DONE:   o.done = 1'b1;
         ST_FAIL:   o.fail = 1'b1;
         default:   o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/i2c_passthru_bus_recovery_if.sv
// Bus-side signals of the recovery sequencer; master = requester/pads side,
// slave = the recovery block itself.
interface i2c_passthru_bus_recovery_if;
   logic i_start;
   logic i_disconnect;
   logic i_sda_a;
   logic i_sda_b;
   logic i_scl_a;
   logic i_scl_b;
   logic o_scl_a_oe;
   logic o_sda_a_oe;
   logic o_scl_b_oe;
   logic o_sda_b_oe;
   logic o_busy;
   logic o_done;
   logic o_fail;

   modport master (
      output i_start, i_disconnect, i_sda_a, i_sda_b, i_scl_a, i_scl_b,
      input  o_scl_a_oe, o_sda_a_oe, o_scl_b_oe, o_sda_b_oe, o_busy, o_done, o_fail
   );

   modport slave (
      input  i_start, i_disconnect, i_sda_a, i_sda_b, i_scl_a, i_scl_b,
      output o_scl_a_oe, o_sda_a_oe, o_scl_b_oe, o_sda_b_oe, o_busy, o_done, o_fail
   );
endinterface

// File: rtl/i2c_passthru_bus_recovery_phase_timer.sv
// Reloadable phase down-counter: loads CLK_DIV-1, counts down to zero and
// rests there; i_hold freezes the count.
module i2c_passthru_phase_timer #(
   parameter int CLK_DIV = 250
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_hold,
   output logic o_zero
);

   localparam int            TW     = $clog2(CLK_DIV);
   localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

   logic [TW-1:0] count_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (i_load) begin
         count_q <= RELOAD;
      end else if (!i_hold && count_q != '0) begin
         count_q <= count_q - TW'(1);
      end
   end

   assign o_zero = (count_q == '0);

endmodule

// File: rtl/i2c_passthru_bus_recovery.sv
// I2C passthru bus-recovery sequencer: clocks SCL on both channels until SDA
// frees up, then issues STOP. Optional I2C_PASSTHRU_RECOVERY_STRETCH_EN honours clock stretching.
module i2c_passthru_bus_recovery
   import i2c_passthru_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEFAULT,
   parameter int PULSE_MAX = PULSE_MAX_DEFAULT
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   i2c_passthru_bus_recovery_if.slave  bus
);

   state_e     state_q;
   state_e     state_d;
   logic [3:0] pulse_cnt_q;
   out_t       out_q;
   logic       timer_load;
   logic       timer_hold;
   logic       timer_zero;
   logic       phase_end;
   logic       sda_free;
   logic       in_sequence;

`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
   assign timer_hold = (state_q == ST_HIGH) && !(bus.i_scl_a && bus.i_scl_b);
`else
   logic unused_scl;
   assign unused_scl = bus.i_scl_a ^ bus.i_scl_b;
   assign timer_hold = 1'b0;
`endif

   // A held timer at zero must not end the phase, so stretching at the tail still counts.
   assign phase_end   = timer_zero && !timer_hold;
   assign sda_free    = bus.i_sda_a && bus.i_sda_b;
   assign in_sequence = state_q inside {ST_LOW, ST_HIGH, ST_STOP_A, ST_STOP_B, ST_STOP_C};

   i2c_passthru_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (timer_load),
      .i_hold (timer_hold),
      .o_zero (timer_zero)
   );

   // NOTE: defaults are assigned first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.i_start && bus.i_disconnect) state_d = ST_LOW;
         ST_LOW:    if (phase_end) state_d = ST_HIGH;
         ST_HIGH: begin
            if (phase_end) begin
               if (sda_free)                        state_d = ST_STOP_A;
               else if (pulse_cnt_q < 4'(PULSE_MAX)) state_d = ST_LOW;
               else                                 state_d = ST_FAIL;
            end
         end
         ST_STOP_A: if (phase_end) state_d = ST_STOP_B;
         ST_STOP_B: if (phase_end) state_d = ST_STOP_C;
         ST_STOP_C: if (phase_end) state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
      if (in_sequence && !bus.i_disconnect) state_d = ST_IDLE;
      timer_load = (state_d != state_q);
   end

   // Outputs are decoded from the next state so they are registered yet aligned with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         pulse_cnt_q <= '0;
         out_q       <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= decode_outputs(state_d);
         if (state_q == ST_IDLE && state_d == ST_LOW) begin
            pulse_cnt_q <= '0;
         end else if (state_q == ST_LOW && state_d == ST_HIGH) begin
            pulse_cnt_q <= pulse_cnt_q + 4'd1;
         end
      end
   end

   assign bus.o_scl_a_oe = out_q.scl_oe;
   assign bus.o_scl_b_oe = out_q.scl_oe;
   assign bus.o_sda_a_oe = out_q.sda_oe;
   assign bus.o_sda_b_oe = out_q.sda_oe;
   assign bus.o_busy     = out_q.busy;
   assign bus.o_done     = out_q.done;
   assign bus.o_fail     = out_q.fail;

endmodule

// File: tb/tb_i2c_passthru_bus_recovery.sv
// Self-checking bench for i2c_passthru_bus_recovery (CLK_DIV=4, PULSE_MAX=9):
// table-driven scenarios plus hand-written reset and stretch sequences, scoreboard-compared.
module tb_i2c_passthru_bus_recovery;

   localparam int CLK_DIV   = 4;
   localparam int PULSE_MAX = 9;

   typedef struct {
      string name;
      int    start2;    // cycle of a second i_start pulse, -1 for none
      bit    disc;      // i_disconnect level for the run
      int    sda_a_rel; // first cycle at which SDA A reads high
      int    sda_b_rel; // first cycle at which SDA B reads high
      int    abort;     // cycle in which i_disconnect drops, -1 for none
      int    pulses;    // expected SCL pulses
      bit    fail;      // expected outcome is o_fail rather than o_done
   } vec_t;

   typedef struct {
      string      tag;
      int         cycle;
      logic [6:0] exp;
   } sb_t;

   logic i_clk = 1'b0;
   logic i_rst;
   int   checks = 0;
   int   errors = 0;
   sb_t  sb_q[$];
   vec_t vecs[6];

   always #5 i_clk = ~i_clk;

   i2c_passthru_bus_recovery_if bus ();

   i2c_passthru_bus_recovery #(
      .CLK_DIV   (CLK_DIV),
      .PULSE_MAX (PULSE_MAX)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   // {scl_a, scl_b, sda_a, sda_b, busy, done, fail}
   function automatic logic [6:0] pack(logic scl, logic sda, logic busy, logic done, logic fail);
      return {scl, scl, sda, sda, busy, done, fail};
   endfunction

   // Expected outputs k cycles after an accepted i_start, for n pulses.
   function automatic logic [6:0] timeline(int k, int n, bit fail);
      int e;
      e = 8 * n;
      if (k < 1) return '0;
      if (k <= e) return (((k - 1) % 8) < 4) ? pack(1, 0, 1, 0, 0) : pack(0, 0, 1, 0, 0);
      if (fail) return (k == e + 1) ? pack(0, 0, 0, 0, 1) : '0;
      if (k <= e + 4)  return pack(1, 1, 1, 0, 0);
      if (k <= e + 8)  return pack(0, 1, 1, 0, 0);
      if (k <= e + 12) return pack(0, 0, 1, 0, 0);
      if (k == e + 13) return pack(0, 0, 0, 1, 0);
      return '0;
   endfunction

   function automatic logic [6:0] vec_expect(vec_t v, int k);
      if (!v.disc) return '0;
      if (v.abort >= 0 && k > v.abort) return '0;
      return timeline(k, v.pulses, v.fail);
   endfunction

   task automatic check(input string name, input int cyc, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b (scl_a scl_b sda_a sda_b busy done fail)",
                  name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected in the following cycle,
   // then compare them once the DUT has produced them.
   task automatic step(input logic st, input logic dis, input logic sa, input logic sb,
                       input logic ca, input logic cb, input logic rs,
                       input logic [6:0] exp_next, input string tag, input int cyc);
      sb_t        e;
      logic [6:0] act;
      i_rst            = rs;
      bus.i_start      = st;
      bus.i_disconnect = dis;
      bus.i_sda_a      = sa;
      bus.i_sda_b      = sb;
      bus.i_scl_a      = ca;
      bus.i_scl_b      = cb;
      e.tag   = tag;
      e.cycle = cyc + 1;
      e.exp   = exp_next;
      sb_q.push_back(e);
      @(posedge i_clk);
      @(negedge i_clk);
      act = {bus.o_scl_a_oe, bus.o_scl_b_oe, bus.o_sda_a_oe, bus.o_sda_b_oe,
             bus.o_busy, bus.o_done, bus.o_fail};
      e = sb_q.pop_front();
      check(e.tag, e.cycle, act, e.exp);
   endtask

   task automatic reset_dut();
      step(0, 0, 1, 1, 1, 1, 1, '0, "reset", -1);
      step(0, 0, 1, 1, 1, 1, 0, '0, "reset_idle", 0);
   endtask

   initial begin
      vecs[0] = '{"sda_high",        -1, 1'b1, 0,    0,  -1, 1, 1'b0};
      vecs[1] = '{"sda_b_late",      -1, 1'b1, 0,    22, -1, 3, 1'b0};
      vecs[2] = '{"sda_a_stuck",     -1, 1'b1, 1000, 0,  -1, 9, 1'b1};
      vecs[3] = '{"abort",           -1, 1'b1, 0,    0,  6,  1, 1'b0};
      vecs[4] = '{"start_repeated",  3,  1'b1, 0,    0,  -1, 1, 1'b0};
      vecs[5] = '{"no_disconnect",   -1, 1'b0, 0,    0,  -1, 1, 1'b0};

      @(negedge i_clk);
      reset_dut();

      for (int i = 0; i < $size(vecs); i++) begin
         int len;
         len = vecs[i].fail ? 8 * vecs[i].pulses + 3 : 8 * vecs[i].pulses + 16;
         for (int c = 0; c < len; c++) begin
            logic st, dis;
            st  = (c == 0) || (c == vecs[i].start2);
            dis = vecs[i].disc && !(vecs[i].abort >= 0 && c >= vecs[i].abort);
            step(st, dis, logic'(c >= vecs[i].sda_a_rel), logic'(c >= vecs[i].sda_b_rel),
                 1, 1, 0, vec_expect(vecs[i], c + 1), vecs[i].name, c);
         end
         reset_dut();
      end

      // Start without disconnect, then a reset mid-STOP and a fresh start.
      for (int c = 0; c < 6; c++) begin
         step(logic'(c == 0), 0, 1, 1, 1, 1, 0, '0, "start_no_disc", c);
      end
      for (int c = 0; c < 32; c++) begin
         logic [6:0] ex;
         int         k;
         k = c + 1;
         if (k <= 14)      ex = timeline(k, 1, 0);
         else if (k <= 16) ex = '0;
         else              ex = timeline(k - 16, 1, 0);
         step(logic'(c == 0 || c == 16), 1, 1, 1, 1, 1, logic'(c == 14), ex, "rst_mid_seq", c);
      end
      reset_dut();

      // SCL A held low for six cycles at the start of the first HIGH phase.
      for (int c = 0; c < 30; c++) begin
         logic [6:0] ex;
         int         k;
         k = c + 1;
`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
         if (k <= 4)       ex = timeline(k, 1, 0);
         else if (k <= 14) ex = pack(0, 0, 1, 0, 0);
         else              ex = timeline(k - 6, 1, 0);
`else
         ex = timeline(k, 1, 0);
`endif
         step(logic'(c == 0), 1, 1, 1, logic'(!(c >= 5 && c <= 10)), 1, 0, ex, "scl_stretch", c);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
